// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
// Shared pipeline definitions for the memory stage: data and register-index
// widths, the memory-stage FSM state encoding and the MEM/WB record layout.
package mem_stage_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 3;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WAIT   = 2'b01,
    HALTED = 2'b10
  } state_t;

  // One MEM/WB boundary record.
  typedef struct packed {
    logic [REG_W-1:0]  w1;
    logic              reg_en;
    logic              mem_to_reg;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] alu_out;
    logic              halt;
    logic              err;
  } mem_wb_t;

  localparam int MEM_WB_W = $bits(mem_wb_t);

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if
// Request/done handshake between the memory stage and the data cache.
//   mem_addr  : byte address of the access
//   mem_wdata : store data
//   mem_rd    : read request
//   mem_wr    : write request
//   mem_rdata : read data, valid with mem_done
//   mem_done  : one-cycle completion pulse
// master = memory stage, slave = cache.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;

  modport master (
    output mem_addr, mem_wdata, mem_rd, mem_wr,
    input  mem_rdata, mem_done
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_rd, mem_wr,
    output mem_rdata, mem_done
  );

endinterface

// File: rtl/dff.sv
// dff
// Generic register cell with asynchronous active-high reset to zero.
//   clk  : clock
//   rst  : asynchronous active-high reset
//   i_d  : next value
//   o_q  : registered value
module dff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) o_q <= '0;
    else     o_q <= i_d;
  end

endmodule

// File: rtl/mem_stage_mem_wb_reg.sv
// mem_wb_reg
// MEM/WB output register bank.
//   clk      : clock
//   rst      : asynchronous active-high reset (all fields to 0)
//   i_hold   : stage is halted; keep halt/err, force reg_en low
//   i_bubble : stage is stalled; insert a bubble
//   i_d      : record to capture on a normal cycle
//   o_q      : registered record
module mem_wb_reg
  import mem_stage_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    i_hold,
  input  logic    i_bubble,
  input  mem_wb_t i_d,
  output mem_wb_t o_q
);

  mem_wb_t w_next;

  always_comb begin
    w_next = i_d;
    if (i_hold) begin
      w_next        = o_q;
      w_next.reg_en = 1'b0;
    end else if (i_bubble) begin
      // Bubble keeps data fields but must never write back or signal.
      w_next            = o_q;
      w_next.reg_en     = 1'b0;
      w_next.mem_to_reg = 1'b0;
      w_next.halt       = 1'b0;
      w_next.err        = 1'b0;
    end
  end

  dff #(.WIDTH(MEM_WB_W)) u_q (
    .clk (clk),
    .rst (rst),
    .i_d (w_next),
    .o_q (o_q)
  );

endmodule

// File: rtl/mem_stage.sv
// mem_stage
// Memory stage of the 16-bit five-stage pipeline. Issues loads/stores from the
// EX/MEM register to the data cache, stalls the front end on a miss, flags
// misaligned accesses and timeouts, and registers results into MEM/WB.
//   clk, rst            : clock, asynchronous active-high reset
//   *_EX_MEM            : fields of the upstream pipeline register
//   mem                 : cache handshake (master side)
//   stall_mem           : freeze PC, IF/ID, ID/EX and EX/MEM
//   *_MEM_WB            : registered MEM/WB boundary
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_W-1:0]  w1_reg_EX_MEM,
  input  logic              reg_en_EX_MEM,
  input  logic              mem_en_EX_MEM,
  input  logic              mem_wr_EX_MEM,
  input  logic [DATA_W-1:0] alu_out_EX_MEM,
  input  logic [DATA_W-1:0] writedata_EX_MEM,
  input  logic              halt_EX_MEM,
  mem_stage_if.master       mem,
  output logic              stall_mem,
  output logic [REG_W-1:0]  w1_reg_MEM_WB,
  output logic              reg_en_MEM_WB,
  output logic              mem_to_reg_MEM_WB,
  output logic [DATA_W-1:0] rdata_MEM_WB,
  output logic [DATA_W-1:0] alu_out_MEM_WB,
  output logic              halt_MEM_WB,
  output logic              err_MEM_WB
);

  logic [1:0]       w_state_q;
  state_t           w_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_rd, w_wr, w_stall, w_hold, w_bubble;
  logic             w_valid, w_misalign;
  mem_wb_t          w_wb_next;
  mem_wb_t          r_wb;

  assign w_state    = state_t'(w_state_q);
  // Halt instructions never access memory, whatever mem_en says.
  assign w_valid    = mem_en_EX_MEM & ~halt_EX_MEM & ~alu_out_EX_MEM[0];
  assign w_misalign = mem_en_EX_MEM & ~halt_EX_MEM &  alu_out_EX_MEM[0];

  always_comb begin
    w_state_next         = w_state;
    w_cnt_next           = r_cnt;
    w_rd                 = 1'b0;
    w_wr                 = 1'b0;
    w_stall              = 1'b0;
    w_hold               = 1'b0;
    w_bubble             = 1'b0;
    w_wb_next.w1         = w1_reg_EX_MEM;
    w_wb_next.reg_en     = reg_en_EX_MEM;
    w_wb_next.mem_to_reg = 1'b0;
    w_wb_next.rdata      = r_wb.rdata;
    w_wb_next.alu_out    = alu_out_EX_MEM;
    w_wb_next.halt       = 1'b0;
    w_wb_next.err        = 1'b0;

    unique case (w_state)
      IDLE: begin
        if (halt_EX_MEM) begin
          w_wb_next.halt = 1'b1;
          w_state_next   = HALTED;
        end else if (w_misalign) begin
          w_wb_next.reg_en = 1'b0;
          w_wb_next.err    = 1'b1;
          w_state_next     = HALTED;
        end else if (w_valid) begin
          w_rd = ~mem_wr_EX_MEM;
          w_wr =  mem_wr_EX_MEM;
          if (mem.mem_done) begin
            w_wb_next.reg_en     = reg_en_EX_MEM & ~mem_wr_EX_MEM;
            w_wb_next.mem_to_reg = ~mem_wr_EX_MEM;
            if (!mem_wr_EX_MEM) w_wb_next.rdata = mem.mem_rdata;
          end else begin
            w_stall      = 1'b1;
            w_bubble     = 1'b1;
            w_cnt_next   = CNT_W'(1);
            w_state_next = WAIT;
          end
        end
      end
      WAIT: begin
        // EX/MEM is frozen while we wait, so its fields still describe the access.
        if (mem.mem_done) begin
          w_rd                 = ~mem_wr_EX_MEM;
          w_wr                 =  mem_wr_EX_MEM;
          w_wb_next.reg_en     = reg_en_EX_MEM & ~mem_wr_EX_MEM;
          w_wb_next.mem_to_reg = ~mem_wr_EX_MEM;
          if (!mem_wr_EX_MEM) w_wb_next.rdata = mem.mem_rdata;
          w_cnt_next   = '0;
          w_state_next = IDLE;
        end else if (r_cnt == CNT_W'(TIMEOUT)) begin
          // Give up: request and stall drop in this cycle, error lands next edge.
          w_wb_next.reg_en = 1'b0;
          w_wb_next.err    = 1'b1;
          w_cnt_next       = '0;
          w_state_next     = HALTED;
        end else begin
          w_rd       = ~mem_wr_EX_MEM;
          w_wr       =  mem_wr_EX_MEM;
          w_stall    = 1'b1;
          w_bubble   = 1'b1;
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      HALTED: begin
        w_hold = 1'b1;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  dff #(.WIDTH(2)) u_state (
    .clk (clk),
    .rst (rst),
    .i_d (w_state_next),
    .o_q (w_state_q)
  );

  dff #(.WIDTH(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .i_d (w_cnt_next),
    .o_q (r_cnt)
  );

  mem_wb_reg u_mem_wb (
    .clk      (clk),
    .rst      (rst),
    .i_hold   (w_hold),
    .i_bubble (w_bubble),
    .i_d      (w_wb_next),
    .o_q      (r_wb)
  );

  // Gate with rst so an in-flight request is withdrawn the moment reset hits,
  // even if the upstream register still presents the access.
  assign mem.mem_rd    = w_rd & ~rst;
  assign mem.mem_wr    = w_wr & ~rst;
  assign mem.mem_addr  = alu_out_EX_MEM;
  assign mem.mem_wdata = writedata_EX_MEM;
  assign stall_mem     = w_stall & ~rst;

  assign w1_reg_MEM_WB     = r_wb.w1;
  assign reg_en_MEM_WB     = r_wb.reg_en;
  assign mem_to_reg_MEM_WB = r_wb.mem_to_reg;
  assign rdata_MEM_WB      = r_wb.rdata;
  assign alu_out_MEM_WB    = r_wb.alu_out;
  assign halt_MEM_WB       = r_wb.halt;
  assign err_MEM_WB        = r_wb.err;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  w1_in;
  logic        reg_en_in, mem_en_in, mem_wr_in, halt_in;
  logic [15:0] alu_in, wdata_in;
  logic        stall_mem;
  logic [2:0]  w1_o;
  logic        reg_en_o, m2r_o, halt_o, err_o;
  logic [15:0] rdata_o, alu_o;

  mem_stage_if mem_bus ();

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk               (clk),
    .rst               (rst),
    .w1_reg_EX_MEM     (w1_in),
    .reg_en_EX_MEM     (reg_en_in),
    .mem_en_EX_MEM     (mem_en_in),
    .mem_wr_EX_MEM     (mem_wr_in),
    .alu_out_EX_MEM    (alu_in),
    .writedata_EX_MEM  (wdata_in),
    .halt_EX_MEM       (halt_in),
    .mem               (mem_bus),
    .stall_mem         (stall_mem),
    .w1_reg_MEM_WB     (w1_o),
    .reg_en_MEM_WB     (reg_en_o),
    .mem_to_reg_MEM_WB (m2r_o),
    .rdata_MEM_WB      (rdata_o),
    .alu_out_MEM_WB    (alu_o),
    .halt_MEM_WB       (halt_o),
    .err_MEM_WB        (err_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [2:0]  w1;
    logic        reg_en, mem_en, mem_wr;
    logic [15:0] alu, wdata, rdata;
    logic        done;
    logic        exp_rd, exp_wr, exp_reg_en, exp_m2r;
  } vec_t;

  vec_t    vecs[6];
  mem_wb_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    w1_in = '0; reg_en_in = 0; mem_en_in = 0; mem_wr_in = 0; halt_in = 0;
    alu_in = '0; wdata_in = '0;
    mem_bus.mem_rdata = '0; mem_bus.mem_done = 0;
  endtask

  task automatic drive(input logic [2:0] w1, input logic ren, input logic men,
                       input logic mwr, input logic [15:0] alu, input logic [15:0] wd,
                       input logic hlt);
    w1_in = w1; reg_en_in = ren; mem_en_in = men; mem_wr_in = mwr;
    alu_in = alu; wdata_in = wd; halt_in = hlt;
  endtask

  task automatic push_exp(input logic [2:0] w1, input logic ren, input logic m2r,
                          input logic [15:0] rd, input logic [15:0] alu);
    mem_wb_t e;
    e = '0;
    e.w1 = w1; e.reg_en = ren; e.mem_to_reg = m2r; e.rdata = rd; e.alu_out = alu;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input string tag);
    mem_wb_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_w1"},     32'(w1_o),     32'(e.w1));
      chk({tag, "_reg_en"}, 32'(reg_en_o), 32'(e.reg_en));
      chk({tag, "_m2r"},    32'(m2r_o),    32'(e.mem_to_reg));
      chk({tag, "_alu"},    32'(alu_o),    32'(e.alu_out));
      chk({tag, "_halt"},   32'(halt_o),   32'(e.halt));
      chk({tag, "_err"},    32'(err_o),    32'(e.err));
      if (e.mem_to_reg) chk({tag, "_rdata"}, 32'(rdata_o), 32'(e.rdata));
      $display("txn %s: w1=%0d reg_en=%0b m2r=%0b rdata=%h alu=%h", tag,
               w1_o, reg_en_o, m2r_o, rdata_o, alu_o);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rd"},     32'(mem_bus.mem_rd), 0);
    chk({tag, "_wr"},     32'(mem_bus.mem_wr), 0);
    chk({tag, "_stall"},  32'(stall_mem), 0);
    chk({tag, "_w1"},     32'(w1_o), 0);
    chk({tag, "_reg_en"}, 32'(reg_en_o), 0);
    chk({tag, "_m2r"},    32'(m2r_o), 0);
    chk({tag, "_rdata"},  32'(rdata_o), 0);
    chk({tag, "_alu"},    32'(alu_o), 0);
    chk({tag, "_halt"},   32'(halt_o), 0);
    chk({tag, "_err"},    32'(err_o), 0);
    $display("txn %s: outputs after reset", tag);
  endtask

  task automatic pulse_reset(input string tag);
    idle_in();
    #2 rst = 1;
    #1 check_zero(tag);
    @(negedge clk);
    rst = 0;
    step();
  endtask

  initial begin
    vecs[0] = '{3'd3, 1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{3'd1, 1'b1, 1'b1, 1'b1, 16'h0022, 16'h5A5A, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{3'd5, 1'b1, 1'b0, 1'b0, 16'h1235, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{3'd7, 1'b1, 1'b1, 1'b0, 16'hFFFE, 16'h0000, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{3'd2, 1'b1, 1'b0, 1'b0, 16'h0F0F, 16'h0000, 16'hDEAD, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{3'd4, 1'b0, 1'b1, 1'b0, 16'h0100, 16'h0000, 16'h1357, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    rst = 1;
    idle_in();
    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk);
    rst = 0;
    step();

    // Back-to-back single-cycle operations (hits, stores, non-memory, stray done).
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].w1, vecs[i].reg_en, vecs[i].mem_en, vecs[i].mem_wr,
            vecs[i].alu, vecs[i].wdata, 1'b0);
      mem_bus.mem_rdata = vecs[i].rdata;
      mem_bus.mem_done  = vecs[i].done;
      #2;
      chk($sformatf("vec%0d_rd", i),    32'(mem_bus.mem_rd), 32'(vecs[i].exp_rd));
      chk($sformatf("vec%0d_wr", i),    32'(mem_bus.mem_wr), 32'(vecs[i].exp_wr));
      chk($sformatf("vec%0d_stall", i), 32'(stall_mem), 0);
      if (vecs[i].exp_rd | vecs[i].exp_wr)
        chk($sformatf("vec%0d_addr", i), 32'(mem_bus.mem_addr), 32'(vecs[i].alu));
      if (vecs[i].exp_wr)
        chk($sformatf("vec%0d_wdata", i), 32'(mem_bus.mem_wdata), 32'(vecs[i].wdata));
      push_exp(vecs[i].w1, vecs[i].exp_reg_en, vecs[i].exp_m2r, vecs[i].rdata, vecs[i].alu);
      step();
      sb_check($sformatf("vec%0d", i));
    end
    idle_in();

    // Store, 3-cycle miss: mem_wr for 3 cycles, stall for 2.
    drive(3'd2, 1'b1, 1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0);
    for (int c = 0; c < 3; c++) begin
      mem_bus.mem_done = (c == 2);
      #2;
      chk($sformatf("st_miss_c%0d_wr", c),    32'(mem_bus.mem_wr), 1);
      chk($sformatf("st_miss_c%0d_rd", c),    32'(mem_bus.mem_rd), 0);
      chk($sformatf("st_miss_c%0d_wdata", c), 32'(mem_bus.mem_wdata), 32'h1234);
      chk($sformatf("st_miss_c%0d_stall", c), 32'(stall_mem), 32'(c < 2));
      if (c == 2) push_exp(3'd2, 1'b0, 1'b0, 16'h0000, 16'h0020);
      step();
      if (c < 2) chk($sformatf("st_miss_c%0d_bubble", c), 32'(reg_en_o), 0);
      else       sb_check("st_miss");
    end
    idle_in();

    // Load whose done coincides with counter == TIMEOUT: completion wins.
    drive(3'd4, 1'b1, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0);
    mem_bus.mem_rdata = 16'hC0DE;
    for (int c = 0; c <= TO; c++) begin
      mem_bus.mem_done = (c == TO);
      #2;
      chk($sformatf("edge_c%0d_rd", c),    32'(mem_bus.mem_rd), 1);
      chk($sformatf("edge_c%0d_stall", c), 32'(stall_mem), 32'(c < TO));
      if (c == TO) push_exp(3'd4, 1'b1, 1'b1, 16'hC0DE, 16'h0040);
      step();
      if (c < TO) chk($sformatf("edge_c%0d_bubble", c), 32'(reg_en_o), 0);
      else        sb_check("ld_done_at_timeout");
    end
    idle_in();

    // Timeout: no done ever arrives.
    drive(3'd5, 1'b1, 1'b1, 1'b0, 16'h0050, 16'h0000, 1'b0);
    for (int c = 0; c <= TO; c++) begin
      #2;
      chk($sformatf("to_c%0d_rd", c),    32'(mem_bus.mem_rd), 32'(c < TO));
      chk($sformatf("to_c%0d_stall", c), 32'(stall_mem), 32'(c < TO));
      step();
      if (c < TO) chk($sformatf("to_c%0d_err", c), 32'(err_o), 0);
    end
    chk("to_err", 32'(err_o), 1);
    chk("to_reg_en", 32'(reg_en_o), 0);
    $display("txn timeout: err=%0b stall=%0b", err_o, stall_mem);
    // Halted: a later load with done is ignored.
    mem_bus.mem_done = 1;
    #2;
    chk("to_halted_rd", 32'(mem_bus.mem_rd), 0);
    chk("to_halted_stall", 32'(stall_mem), 0);
    step();
    chk("to_halted_err", 32'(err_o), 1);
    chk("to_halted_reg_en", 32'(reg_en_o), 0);
    pulse_reset("rst_after_timeout");

    // Misaligned load.
    drive(3'd1, 1'b1, 1'b1, 1'b0, 16'h0011, 16'h0000, 1'b0);
    mem_bus.mem_done = 1;
    #2;
    chk("mis_rd", 32'(mem_bus.mem_rd), 0);
    chk("mis_stall", 32'(stall_mem), 0);
    step();
    chk("mis_err", 32'(err_o), 1);
    chk("mis_reg_en", 32'(reg_en_o), 0);
    $display("txn misaligned: err=%0b", err_o);
    drive(3'd1, 1'b1, 1'b1, 1'b0, 16'h0012, 16'h0000, 1'b0);
    #2;
    chk("mis_halted_rd", 32'(mem_bus.mem_rd), 0);
    step();
    chk("mis_halted_err", 32'(err_o), 1);
    chk("mis_halted_reg_en", 32'(reg_en_o), 0);
    pulse_reset("rst_after_mis");

    // Halt with mem_en set.
    drive(3'd3, 1'b0, 1'b1, 1'b0, 16'h0060, 16'h0000, 1'b1);
    mem_bus.mem_done = 1;
    #2;
    chk("halt_rd", 32'(mem_bus.mem_rd), 0);
    chk("halt_wr", 32'(mem_bus.mem_wr), 0);
    step();
    chk("halt_flag", 32'(halt_o), 1);
    chk("halt_err", 32'(err_o), 0);
    $display("txn halt: halt=%0b", halt_o);
    drive(3'd3, 1'b1, 1'b1, 1'b0, 16'h0062, 16'h0000, 1'b0);
    #2;
    chk("halt_later_rd", 32'(mem_bus.mem_rd), 0);
    step();
    chk("halt_sticky", 32'(halt_o), 1);
    chk("halt_later_reg_en", 32'(reg_en_o), 0);
    pulse_reset("rst_after_halt");

    // Reset in the middle of a miss.
    drive(3'd6, 1'b1, 1'b1, 1'b0, 16'h0070, 16'h0000, 1'b0);
    #2;
    chk("rw_issue_stall", 32'(stall_mem), 1);
    step();
    #2;
    chk("rw_wait_rd", 32'(mem_bus.mem_rd), 1);
    chk("rw_wait_stall", 32'(stall_mem), 1);
    rst = 1;
    #1 check_zero("rst_mid_wait");
    idle_in();
    @(negedge clk);
    rst = 0;
    step();
    drive(3'd6, 1'b1, 1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0);
    mem_bus.mem_rdata = 16'hA5A5;
    mem_bus.mem_done  = 1;
    #2;
    chk("fresh_rd", 32'(mem_bus.mem_rd), 1);
    chk("fresh_stall", 32'(stall_mem), 0);
    push_exp(3'd6, 1'b1, 1'b1, 16'hA5A5, 16'h0030);
    step();
    sb_check("fresh_load");
    idle_in();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
